// File: rtl/mips_controller.sv
// Multicycle control FSM for the 8-bit MIPS datapath: four byte fetches, decode, execute, memory, writeback.
// Optional ADDI support is compiled in when the CTRL_ADDI_EN macro is defined.
module mips_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic       iord,
    output logic [3:0] irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       pcen,
    output logic [1:0] pcsource
);

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,
        FETCH2  = 4'd1,
        FETCH3  = 4'd2,
        FETCH4  = 4'd3,
        DECODE  = 4'd4,
        MEMADR  = 4'd5,
        LBRD    = 4'd6,
        LBWR    = 4'd7,
        SBWR    = 4'd8,
        RTYPEEX = 4'd9,
        RTYPEWR = 4'd10,
        BEQEX   = 4'd11,
`ifdef CTRL_ADDI_EN
        ADDIEX  = 4'd13,
        ADDIWR  = 4'd14,
`endif
        JEX     = 4'd12
    } state_t;

    state_t state;
    logic   pcwrite;
    logic   pcwritecond;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH1;
        end else begin
            case (state)
                FETCH1:  state <= FETCH2;
                FETCH2:  state <= FETCH3;
                FETCH3:  state <= FETCH4;
                FETCH4:  state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LB, OP_SB: state <= MEMADR;
                        OP_RTYPE:     state <= RTYPEEX;
                        OP_BEQ:       state <= BEQEX;
                        OP_J:         state <= JEX;
`ifdef CTRL_ADDI_EN
                        OP_ADDI:      state <= ADDIEX;
`endif
                        default:      state <= FETCH1;
                    endcase
                end
                MEMADR: begin
                    if (op == OP_LB)      state <= LBRD;
                    else if (op == OP_SB) state <= SBWR;
                    else                  state <= FETCH1;
                end
                LBRD:    state <= LBWR;
                LBWR:    state <= FETCH1;
                SBWR:    state <= FETCH1;
                RTYPEEX: state <= RTYPEWR;
                RTYPEWR: state <= FETCH1;
                BEQEX:   state <= FETCH1;
                JEX:     state <= FETCH1;
`ifdef CTRL_ADDI_EN
                ADDIEX:  state <= ADDIWR;
                ADDIWR:  state <= FETCH1;
`endif
                default: state <= FETCH1;
            endcase
        end
    end

    // Outputs are forced low while reset is held so no strobe leaks out of the reset cycle,
    // even though the state register only returns to FETCH1 on the next edge.
    always_comb begin
        memread     = 1'b0;
        memwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        alucontrol  = 3'b000;
        iord        = 1'b0;
        irwrite     = '0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        pcsource    = 2'b00;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        if (!reset) begin
            alucontrol = 3'b010;
            case (state)
                FETCH1, FETCH2, FETCH3, FETCH4: begin
                    memread = 1'b1;
                    irwrite = 4'b0001 << state[1:0];
                    alusrcb = 2'b01;
                    pcwrite = 1'b1;
                end
                DECODE:  alusrcb = 2'b11;
                MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                LBRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                LBWR: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                SBWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                RTYPEEX: begin
                    alusrca = 1'b1;
                    case (funct)
                        FN_ADD:  alucontrol = 3'b010;
                        FN_SUB:  alucontrol = 3'b110;
                        FN_AND:  alucontrol = 3'b000;
                        FN_OR:   alucontrol = 3'b001;
                        FN_SLT:  alucontrol = 3'b111;
                        default: alucontrol = 3'b010;
                    endcase
                end
                RTYPEWR: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                BEQEX: begin
                    alusrca     = 1'b1;
                    alucontrol  = 3'b110;
                    pcwritecond = 1'b1;
                    pcsource    = 2'b01;
                end
                JEX: begin
                    pcwrite  = 1'b1;
                    pcsource = 2'b10;
                end
`ifdef CTRL_ADDI_EN
                ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                ADDIWR:  regwrite = 1'b1;
`endif
                default: ;
            endcase
        end
        pcen = pcwrite | (pcwritecond & zero);
    end

endmodule

// File: tb/tb_mips_controller.sv
// Directed bench for mips_controller: walks each instruction class state by state.
// Expectations for op=001000 follow the CTRL_ADDI_EN macro.
module tb_mips_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memread, memwrite, alusrca, iord, memtoreg, regdst, regwrite, pcen;
    logic [1:0] alusrcb, pcsource;
    logic [2:0] alucontrol;
    logic [3:0] irwrite;

    int tests = 0;
    int fails = 0;

    mips_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .alucontrol(alucontrol), .iord(iord), .irwrite(irwrite), .memtoreg(memtoreg),
        .regdst(regdst), .regwrite(regwrite), .pcen(pcen), .pcsource(pcsource)
    );

    always #5 clk = ~clk;

    logic [18:0] obs;
    assign obs = {memread, memwrite, alusrca, alusrcb, alucontrol, iord, irwrite,
                  memtoreg, regdst, regwrite, pcen, pcsource};

    // Field order: memread memwrite alusrca alusrcb alucontrol iord irwrite memtoreg regdst regwrite pcen pcsource
    function automatic logic [18:0] ev(input logic mr, input logic mw, input logic asa,
                                       input logic [1:0] asb, input logic [2:0] ac,
                                       input logic io, input logic [3:0] irw, input logic m2r,
                                       input logic rd, input logic rw, input logic pe,
                                       input logic [1:0] ps);
        return {mr, mw, asa, asb, ac, io, irw, m2r, rd, rw, pe, ps};
    endfunction

    task automatic chk(input string tag, input logic [18:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Enters in FETCH1, leaves in DECODE (checked).
    task automatic fetch_decode(input string tag);
        chk({tag, ".f1"}, ev(1, 0, 0, 2'b01, 3'b010, 0, 4'b0001, 0, 0, 0, 1, 2'b00));
        step();
        chk({tag, ".f2"}, ev(1, 0, 0, 2'b01, 3'b010, 0, 4'b0010, 0, 0, 0, 1, 2'b00));
        step();
        chk({tag, ".f3"}, ev(1, 0, 0, 2'b01, 3'b010, 0, 4'b0100, 0, 0, 0, 1, 2'b00));
        step();
        chk({tag, ".f4"}, ev(1, 0, 0, 2'b01, 3'b010, 0, 4'b1000, 0, 0, 0, 1, 2'b00));
        step();
        chk({tag, ".dec"}, ev(0, 0, 0, 2'b11, 3'b010, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
    endtask

    task automatic expect_fetch1(input string tag);
        chk({tag, ".back_f1"}, ev(1, 0, 0, 2'b01, 3'b010, 0, 4'b0001, 0, 0, 0, 1, 2'b00));
    endtask

    task automatic run_rtype(input string tag, input logic [5:0] fn, input logic [2:0] ac);
        op = 6'b000000;
        funct = fn;
        fetch_decode(tag);
        step();
        chk({tag, ".ex"}, ev(0, 0, 1, 2'b00, ac, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step();
        chk({tag, ".wr"}, ev(0, 0, 0, 2'b00, 3'b010, 0, 4'b0000, 0, 1, 1, 0, 2'b00));
        step();
        expect_fetch1(tag);
    endtask

    initial begin
        reset = 1'b1;
        op = 6'b000000;
        funct = 6'b000000;
        zero = 1'b0;
        #1;
        chk("reset.pre_edge", '0);
        step();
        chk("reset.cyc1", '0);
        step();
        chk("reset.cyc2", '0);
        reset = 1'b0;
        #1;

        run_rtype("add", 6'b100000, 3'b010);
        run_rtype("slt", 6'b101010, 3'b111);
        run_rtype("sub", 6'b100010, 3'b110);
        run_rtype("and", 6'b100100, 3'b000);
        run_rtype("or",  6'b100101, 3'b001);
        run_rtype("badfn", 6'b111111, 3'b010);

        op = 6'b100000;
        fetch_decode("lb");
        step();
        chk("lb.memadr", ev(0, 0, 1, 2'b10, 3'b010, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step();
        chk("lb.rd", ev(1, 0, 0, 2'b00, 3'b010, 1, 4'b0000, 0, 0, 0, 0, 2'b00));
        step();
        chk("lb.wr", ev(0, 0, 0, 2'b00, 3'b010, 0, 4'b0000, 1, 0, 1, 0, 2'b00));
        step();
        expect_fetch1("lb");

        op = 6'b101000;
        fetch_decode("sb");
        step();
        chk("sb.memadr", ev(0, 0, 1, 2'b10, 3'b010, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step();
        chk("sb.wr", ev(0, 1, 0, 2'b00, 3'b010, 1, 4'b0000, 0, 0, 0, 0, 2'b00));
        step();
        expect_fetch1("sb");

        op = 6'b000100;
        fetch_decode("beq_t");
        step();
        zero = 1'b1;
        #1;
        chk("beq_t.ex", ev(0, 0, 1, 2'b00, 3'b110, 0, 4'b0000, 0, 0, 0, 1, 2'b01));
        step();
        zero = 1'b0;
        #1;
        expect_fetch1("beq_t");

        fetch_decode("beq_n");
        step();
        chk("beq_n.ex", ev(0, 0, 1, 2'b00, 3'b110, 0, 4'b0000, 0, 0, 0, 0, 2'b01));
        step();
        expect_fetch1("beq_n");

        op = 6'b000010;
        fetch_decode("j");
        step();
        chk("j.ex", ev(0, 0, 0, 2'b00, 3'b010, 0, 4'b0000, 0, 0, 0, 1, 2'b10));
        step();
        expect_fetch1("j");

        op = 6'b111111;
        fetch_decode("nop");
        step();
        expect_fetch1("nop");

        op = 6'b001000;
        fetch_decode("addi");
        step();
`ifdef CTRL_ADDI_EN
        chk("addi.ex", ev(0, 0, 1, 2'b10, 3'b010, 0, 4'b0000, 0, 0, 0, 0, 2'b00));
        step();
        chk("addi.wr", ev(0, 0, 0, 2'b00, 3'b010, 0, 4'b0000, 0, 0, 1, 0, 2'b00));
        step();
`endif
        expect_fetch1("addi");

        op = 6'b100000;
        fetch_decode("lb_rst");
        step();
        step();
        chk("lb_rst.rd", ev(1, 0, 0, 2'b00, 3'b010, 1, 4'b0000, 0, 0, 0, 0, 2'b00));
        reset = 1'b1;
        #1;
        chk("lb_rst.in_reset", '0);
        step();
        reset = 1'b0;
        #1;
        expect_fetch1("lb_rst");
        step();
        chk("lb_rst.f2", ev(1, 0, 0, 2'b01, 3'b010, 0, 4'b0010, 0, 0, 0, 1, 2'b00));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
